// File: rtl/mesh_seq_if.sv
//------------------------------------------------------------------------------
// mesh_seq_if : host-side streams, mesh control bus and result handshake
//               for mesh_seq_ctrl.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mesh_seq_if #(
  parameter int DW    = 8,
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int ROW_W = 2,
  parameter int COL_W = 2,
  parameter int ACC_W = 16
);
  logic                   start;
  logic                   load_w;
  logic                   w_valid;
  logic [DW-1:0]          w_data;
  logic                   w_ready;
  logic                   x_valid;
  logic [COLS*DW-1:0]     x_data;
  logic                   x_ready;
  logic                   cfg_valid;
  logic [ROW_W+COL_W-1:0] cfg_addr;
  logic [DW-1:0]          cfg_data;
  logic [1:0]             global_state;
  logic [COLS*DW-1:0]     x_vector_flat;
  logic [ROWS*ACC_W-1:0]  result_flat;
  logic                   res_valid;
  logic [ROWS*ACC_W-1:0]  res_data;
  logic                   res_ready;
  logic                   busy;

  modport master (
    output start, load_w, w_valid, w_data, x_valid, x_data, result_flat, res_ready,
    input  w_ready, x_ready, cfg_valid, cfg_addr, cfg_data, global_state,
           x_vector_flat, res_valid, res_data, busy
  );

  modport slave (
    input  start, load_w, w_valid, w_data, x_valid, x_data, result_flat, res_ready,
    output w_ready, x_ready, cfg_valid, cfg_addr, cfg_data, global_state,
           x_vector_flat, res_valid, res_data, busy
  );
endinterface

`default_nettype wire

// File: rtl/mesh_seq_ctrl.sv
//------------------------------------------------------------------------------
// mesh_seq_ctrl : sequences weight load, x capture, mesh phases and result
//                 return for one mesh_2d_array pass per start.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mesh_seq_ctrl #(
  parameter int DW      = 8,
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int ROW_W   = 2,
  parameter int COL_W   = 2,
  parameter int ACC_W   = 16,
  parameter int X_CYC   = 4,
  parameter int ACC_CYC = 4
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  mesh_seq_if.slave   bus
);

  localparam int PH_MAX = (X_CYC > ACC_CYC) ? X_CYC : ACC_CYC;
  localparam int PH_W   = $clog2(PH_MAX) + 1;

  localparam logic [PH_W-1:0]  c_X_LAST   = PH_W'(X_CYC - 1);
  localparam logic [PH_W-1:0]  c_ACC_LAST = PH_W'(ACC_CYC - 1);
  localparam logic [ROW_W-1:0] c_ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] c_COL_LAST = COL_W'(COLS - 1);

  localparam logic [2:0] c_S_IDLE   = 3'd0;
  localparam logic [2:0] c_S_CFG    = 3'd1;
  localparam logic [2:0] c_S_WAIT_X = 3'd2;
  localparam logic [2:0] c_S_XPROP  = 3'd3;
  localparam logic [2:0] c_S_ACC    = 3'd4;
  localparam logic [2:0] c_S_CAP    = 3'd5;
  localparam logic [2:0] c_S_OUT    = 3'd6;

  logic [2:0]            r_state;
  logic [ROW_W-1:0]      r_row;
  logic [COL_W-1:0]      r_col;
  logic [PH_W-1:0]       r_phase;
  logic [COLS*DW-1:0]    r_xvec;
  logic [ROWS*ACC_W-1:0] r_res;
  logic                  r_res_valid;

  logic w_in_cfg;
  logic w_beat;
  logic w_col_last;
  logic w_row_last;

  assign w_in_cfg   = (r_state == c_S_CFG);
  assign w_beat     = w_in_cfg & bus.w_valid;
  assign w_col_last = (r_col == c_COL_LAST);
  assign w_row_last = (r_row == c_ROW_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_S_IDLE;
      r_row       <= '0;
      r_col       <= '0;
      r_phase     <= '0;
      r_xvec      <= '0;
      r_res       <= '0;
      r_res_valid <= 1'b0;
    end else begin
      case (r_state)
        c_S_IDLE: begin
          if (bus.start)
            r_state <= bus.load_w ? c_S_CFG : c_S_WAIT_X;
        end
        c_S_CFG: begin
          if (w_beat) begin
            if (w_row_last && w_col_last) begin
              r_row   <= '0;
              r_col   <= '0;
              r_state <= c_S_WAIT_X;
            end else if (w_col_last) begin
              r_col <= '0;
              r_row <= r_row + ROW_W'(1);
            end else begin
              r_col <= r_col + COL_W'(1);
            end
          end
        end
        c_S_WAIT_X: begin
          if (bus.x_valid) begin
            r_xvec  <= bus.x_data;
            r_phase <= '0;
            r_state <= c_S_XPROP;
          end
        end
        c_S_XPROP: begin
          if (r_phase == c_X_LAST) begin
            r_phase <= '0;
            r_state <= c_S_ACC;
          end else begin
            r_phase <= r_phase + PH_W'(1);
          end
        end
        c_S_ACC: begin
          if (r_phase == c_ACC_LAST) begin
            r_phase <= '0;
            r_state <= c_S_CAP;
          end else begin
            r_phase <= r_phase + PH_W'(1);
          end
        end
        c_S_CAP: begin
          r_state <= c_S_OUT;
        end
        c_S_OUT: begin
          // First OUT cycle grabs the mesh result registered during CAP.
          if (!r_res_valid) begin
            r_res       <= bus.result_flat;
            r_res_valid <= 1'b1;
          end else if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= c_S_IDLE;
          end
        end
        default: begin
          r_state <= c_S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    case (r_state)
      c_S_XPROP: bus.global_state = 2'd1;
      c_S_ACC:   bus.global_state = 2'd2;
      c_S_CAP:   bus.global_state = 2'd3;
      default:   bus.global_state = 2'd0;
    endcase
  end

  assign bus.w_ready       = w_in_cfg;
  assign bus.x_ready       = (r_state == c_S_WAIT_X);
  assign bus.cfg_valid     = w_beat;
  assign bus.cfg_addr      = {r_row, r_col};
  assign bus.cfg_data      = w_in_cfg ? bus.w_data : '0;
  assign bus.x_vector_flat = r_xvec;
  assign bus.res_valid     = r_res_valid;
  assign bus.res_data      = r_res;
  assign bus.busy          = (r_state != c_S_IDLE);

endmodule

`default_nettype wire
